// File: rtl/uart_pkg.sv
// Shared UART definitions: baud-cycle arithmetic, fractional addition
// patterns, parity modes and transmitter states.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_ODD,
    PAR_EVEN
  } parity_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_e;

  // Baud ratio in tenths of a clock, rounded to nearest.
  function automatic int unsigned baud_ratio(input longint unsigned clk_freq,
                                             input longint unsigned baud_rate);
    return 32'((clk_freq * 20 + baud_rate) / (baud_rate * 2));
  endfunction

  function automatic int unsigned baud_cycles(input longint unsigned clk_freq,
                                              input longint unsigned baud_rate);
    return baud_ratio(clk_freq, baud_rate) / 10;
  endfunction

  function automatic int unsigned baud_frac(input longint unsigned clk_freq,
                                            input longint unsigned baud_rate);
    return baud_ratio(clk_freq, baud_rate) % 10;
  endfunction

  // Bit k of the result is the extra clock added to bit slot (k mod 10).
  function automatic logic [9:0] addition_pattern(input int unsigned frac);
    logic [9:0] pat;
    case (frac)
      1:       pat = 10'b0000010000;
      2:       pat = 10'b0010000100;
      3:       pat = 10'b0010010010;
      4:       pat = 10'b0101001010;
      5:       pat = 10'b0101010101;
      6:       pat = 10'b1010110101;
      7:       pat = 10'b1101101101;
      8:       pat = 10'b1101111011;
      9:       pat = 10'b1111101111;
      default: pat = 10'b0000000000;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/uart_fifo_sync.sv
// Synchronous byte FIFO, show-ahead read; depth 4 for EA<3, else 2^EA.
module uart_fifo_sync #(
  parameter int unsigned EA = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       empty
);

  localparam int unsigned AW    = (EA < 3) ? 2 : EA;
  localparam int unsigned DEPTH = 1 << AW;

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic        wr_fire, rd_fire;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_fire = wr_en & ~full;
  assign rd_fire = rd_en & ~empty;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: AXI-Stream byte in, framed serial out with fractional
// baud timing, optional parity, 1/2 stop bits and optional TX FIFO.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 115200,
  parameter string       PARITY    = "NONE",
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned FIFO_EA   = 0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_tvalid,
  output logic       o_tready,
  input  logic [7:0] i_tdata,
  output logic       o_uart_tx,
  output logic       o_busy
);

  localparam int unsigned BAUD_CYC = baud_cycles(CLK_FREQ, BAUD_RATE);
  localparam int unsigned FRAC     = baud_frac(CLK_FREQ, BAUD_RATE);
  localparam logic [9:0]  ADD_PAT  = addition_pattern(FRAC);
  localparam int unsigned CW       = $clog2(BAUD_CYC + 2);
  localparam parity_e     PAR_MODE = (PARITY == "ODD")  ? PAR_ODD  :
                                     (PARITY == "EVEN") ? PAR_EVEN : PAR_NONE;

  tx_state_e     state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    slot_q, slot_d;
  logic [2:0]    bit_q, bit_d;
  logic          stop_q, stop_d;
  logic          tx_q, tx_d;

  logic [CW-1:0] slot_len;
  logic          slot_end;
  logic          start;
  logic          pop;
  logic          load_avail;
  logic [7:0]    load_data;
  logic          fifo_empty;

  generate
    if (FIFO_EA > 0) begin : g_fifo
      logic fifo_full;

      uart_fifo_sync #(.EA(FIFO_EA)) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (i_tvalid),
        .wr_data (i_tdata),
        .full    (fifo_full),
        .rd_en   (pop),
        .rd_data (load_data),
        .empty   (fifo_empty)
      );

      assign o_tready   = ~fifo_full;
      assign load_avail = ~fifo_empty;
    end else begin : g_direct
      logic unused_pop;

      assign unused_pop = pop;
      assign fifo_empty = 1'b1;
      assign load_data  = i_tdata;
      assign o_tready   = rstn & (state_q == S_IDLE);
      assign load_avail = i_tvalid & o_tready;
    end
  endgenerate

  assign slot_len  = CW'(BAUD_CYC) + CW'(ADD_PAT[slot_q]);
  assign o_uart_tx = tx_q;
  assign o_busy    = (state_q != S_IDLE) | ~fifo_empty;

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    par_d    = par_q;
    cnt_d    = cnt_q;
    slot_d   = slot_q;
    bit_d    = bit_q;
    stop_d   = stop_q;
    tx_d     = tx_q;
    start    = 1'b0;
    slot_end = (cnt_q == slot_len);

    if (state_q == S_IDLE) begin
      tx_d  = 1'b1;
      start = load_avail;
    end else if (!slot_end) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d  = CW'(1);
      slot_d = (slot_q == 4'd9) ? '0 : slot_q + 4'd1;
      case (state_q)
        S_START: begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
        S_DATA: begin
          if (bit_q != 3'd7) begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end else if (PAR_MODE != PAR_NONE) begin
            state_d = S_PARITY;
            tx_d    = par_q;
          end else begin
            state_d = S_STOP;
            tx_d    = 1'b1;
            stop_d  = 1'b0;
          end
        end
        S_PARITY: begin
          state_d = S_STOP;
          tx_d    = 1'b1;
          stop_d  = 1'b0;
        end
        S_STOP: begin
          // A queued byte chains straight into the next start bit.
          if (STOP_BITS == 2 && !stop_q) begin
            stop_d = 1'b1;
          end else if (load_avail) begin
            start = 1'b1;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (start) begin
      state_d = S_START;
      shift_d = load_data;
      par_d   = (PAR_MODE == PAR_ODD) ? ~^load_data : ^load_data;
      cnt_d   = CW'(1);
      slot_d  = '0;
      bit_d   = '0;
      stop_d  = 1'b0;
      tx_d    = 1'b0;
    end
    pop = start;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      par_q   <= 1'b0;
      cnt_q   <= '0;
      slot_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three configurations checked cycle by cycle against a
// waveform model built from frame rules and baud arithmetic.
module tb_uart_tx;

  localparam int P0_CLK = 100;
  localparam int P0_BAUD = 10;
  localparam int P1_CLK = 1_000_000;
  localparam int P1_BAUD = 115200;
  localparam int P2_CLK = 1_000_000;
  localparam int P2_BAUD = 115200;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       tv [3];
  logic [7:0] td [3];
  logic       rdy [3];
  logic       tx [3];
  logic       busy [3];

  int n_checks = 0;
  int n_errors = 0;

  bit         exp_w[$];
  logic [7:0] byte_q[$];

  string add_pat [10] = '{"0000000000", "0000010000", "0010000100", "0010010010",
                          "0101001010", "0101010101", "1010110101", "1101101101",
                          "1101111011", "1111101111"};

  always #5 clk = ~clk;

  uart_tx #(.CLK_FREQ(P0_CLK), .BAUD_RATE(P0_BAUD), .PARITY("NONE"),
            .STOP_BITS(1), .FIFO_EA(0)) u_plain (
    .clk(clk), .rstn(rstn), .i_tvalid(tv[0]), .o_tready(rdy[0]),
    .i_tdata(td[0]), .o_uart_tx(tx[0]), .o_busy(busy[0]));

  uart_tx #(.CLK_FREQ(P1_CLK), .BAUD_RATE(P1_BAUD), .PARITY("EVEN"),
            .STOP_BITS(2), .FIFO_EA(0)) u_par (
    .clk(clk), .rstn(rstn), .i_tvalid(tv[1]), .o_tready(rdy[1]),
    .i_tdata(td[1]), .o_uart_tx(tx[1]), .o_busy(busy[1]));

  uart_tx #(.CLK_FREQ(P2_CLK), .BAUD_RATE(P2_BAUD), .PARITY("ODD"),
            .STOP_BITS(1), .FIFO_EA(2)) u_fifo (
    .clk(clk), .rstn(rstn), .i_tvalid(tv[2]), .o_tready(rdy[2]),
    .i_tdata(td[2]), .o_uart_tx(tx[2]), .o_busy(busy[2]));

  task automatic check(input string tag, input logic obs, input logic exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  // Append the per-clock line levels of one frame to exp_w.
  function automatic void build_frame(input int id, input logic [7:0] b);
    longint cf, br, r;
    int     pm, stops, bc, fr;
    bit     lv[$];
    case (id)
      0:       begin cf = P0_CLK; br = P0_BAUD; pm = 0; stops = 1; end
      1:       begin cf = P1_CLK; br = P1_BAUD; pm = 2; stops = 2; end
      default: begin cf = P2_CLK; br = P2_BAUD; pm = 1; stops = 1; end
    endcase
    r  = (cf * 20 + br) / (br * 2);
    bc = int'(r / 10);
    fr = int'(r % 10);
    lv.push_back(1'b0);
    for (int j = 0; j < 8; j++) lv.push_back(b[j]);
    if (pm == 2) lv.push_back(($countones(b) % 2) == 1);
    if (pm == 1) lv.push_back(($countones(b) % 2) == 0);
    for (int s = 0; s < stops; s++) lv.push_back(1'b1);
    foreach (lv[k]) begin
      int n;
      n = bc + ((add_pat[fr][9 - (k % 10)] == "1") ? 1 : 0);
      repeat (n) exp_w.push_back(lv[k]);
    end
  endfunction

  // Single frame through a FIFO-less instance, optionally cut by reset.
  task automatic send_frame(input int id, input logic [7:0] b, input int cut_at);
    exp_w.delete();
    build_frame(id, b);
    @(negedge clk);
    check($sformatf("d%0d_ready_idle", id), rdy[id], 1'b1);
    tv[id] = 1'b1;
    td[id] = b;
    @(posedge clk);
    #1;
    tv[id] = 1'b0;
    td[id] = 8'($urandom);
    for (int i = 0; i < exp_w.size(); i++) begin
      @(negedge clk);
      check($sformatf("d%0d_b%02h_tx_c%0d", id, b, i), tx[id], exp_w[i]);
      check($sformatf("d%0d_tready_low_c%0d", id, i), rdy[id], 1'b0);
      check($sformatf("d%0d_busy_c%0d", id, i), busy[id], 1'b1);
      td[id] = 8'($urandom);
      if (i == cut_at) begin
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("rst_tx_high", tx[id], 1'b1);
        check("rst_busy_low", busy[id], 1'b0);
        check("rst_tready_low", rdy[id], 1'b0);
        check("rst_fifo_tready", rdy[2], 1'b1);
        check("rst_fifo_empty", busy[2], 1'b0);
        rstn = 1'b1;
        break;
      end
    end
    @(negedge clk);
    check($sformatf("d%0d_end_tx", id), tx[id], 1'b1);
    check($sformatf("d%0d_end_busy", id), busy[id], 1'b0);
    check($sformatf("d%0d_end_tready", id), rdy[id], 1'b1);
  endtask

  // Stream byte_q into the FIFO instance with valid held high.
  task automatic send_fifo(output int first_drop);
    int acc;
    acc = 0;
    first_drop = -1;
    exp_w.delete();
    foreach (byte_q[j]) build_frame(2, byte_q[j]);
    @(negedge clk);
    fork
      begin
        tv[2] = 1'b1;
        for (int cyc = 0; cyc < 4000 && acc < byte_q.size(); cyc++) begin
          logic r;
          r = rdy[2];
          td[2] = byte_q[acc];
          @(posedge clk);
          if (r) acc++;
          else if (first_drop < 0) first_drop = acc;
          @(negedge clk);
        end
        tv[2] = 1'b0;
        td[2] = 8'($urandom);
      end
      begin
        @(negedge clk);
        check("fifo_pending_tx", tx[2], 1'b1);
        check("fifo_pending_busy", busy[2], 1'b1);
        for (int i = 0; i < exp_w.size(); i++) begin
          @(negedge clk);
          check($sformatf("fifo_tx_c%0d", i), tx[2], exp_w[i]);
          check($sformatf("fifo_busy_c%0d", i), busy[2], 1'b1);
        end
        @(negedge clk);
        check("fifo_end_tx", tx[2], 1'b1);
        check("fifo_end_busy", busy[2], 1'b0);
        check("fifo_end_tready", rdy[2], 1'b1);
      end
    join
    check($sformatf("fifo_all_accepted_%0d", acc), acc == byte_q.size(), 1'b1);
  endtask

  initial begin
    int drop;
    for (int i = 0; i < 3; i++) begin
      tv[i] = 1'b0;
      td[i] = '0;
    end

    rstn = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_tx_d%0d", i), tx[i], 1'b1);
      check($sformatf("reset_busy_d%0d", i), busy[i], 1'b0);
      check($sformatf("reset_tready_d%0d", i), rdy[i], i == 2);
    end
    rstn = 1'b1;

    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        check($sformatf("idle_tx_d%0d", i), tx[i], 1'b1);
        check($sformatf("idle_busy_d%0d", i), busy[i], 1'b0);
        check($sformatf("idle_tready_d%0d", i), rdy[i], 1'b1);
      end
    end

    send_frame(0, 8'h55, -1);
    for (int n = 0; n < 3; n++) send_frame(0, 8'($urandom), -1);

    send_frame(1, 8'h07, -1);
    send_frame(1, 8'hA3, -1);
    for (int n = 0; n < 3; n++) send_frame(1, 8'($urandom), -1);

    byte_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_fifo(drop);
    check($sformatf("fifo_drop_after_%0d", drop), drop == 4 || drop == 5, 1'b1);
    byte_q = {8'h07};
    send_fifo(drop);
    byte_q = {8'($urandom), 8'($urandom), 8'($urandom)};
    send_fifo(drop);

    send_frame(0, 8'hFF, 42);
    send_frame(0, 8'h3C, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter. Accepts bytes on an AXI-Stream slave and serialises each byte onto a UART TX line as a frame: start bit, 8 data bits LSB first, optional parity bit, then 1 or 2 stop bits. It is the transmit counterpart of the RX path, with the same baud-cycle generation, parity options and optional FIFO-depth encoding, so both ends of a link are configured identically.

Parameters:
CLK_FREQ, 50_000_000, clock frequency in Hz
BAUD_RATE, 115200, baud rate in Hz
PARITY, "NONE", one of "NONE", "ODD" or "EVEN"
STOP_BITS, 1, number of stop bits: 1 or 2
FIFO_EA, 0, TX FIFO depth: 0 means no FIFO; 1 or 2 mean depth 4; N≥3 means depth 2^N

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset, sampled on the rising edge of clk
i_tvalid  in  1  AXI-Stream slave valid
o_tready  out  1  AXI-Stream slave ready
i_tdata  in  8  byte to transmit
o_uart_tx  out  1  UART TX line; idle level is high
o_busy  out  1  high while a frame is being shifted out or the FIFO is non-empty

Behaviour:
- Reset: one clock and a synchronous active-low reset. While rstn=0, at each clk edge:
  - o_uart_tx=1, o_busy=0.
  - o_tready=0 when FIFO_EA=0; otherwise 1 (FIFO is empty).
  - FSM returns to S_IDLE; FIFO pointers and counters clear.
  - A frame in progress is abandoned and the line returns high immediately.
- Baud timing:
  - R = (CLK_FREQ*20 + BAUD_RATE) / (BAUD_RATE*2), integer division.
  - BAUD_CYCLES = R/10; FRAC = R%10.
  - A 10-bit ADDITION pattern is chosen by FRAC:
    - 0: 0000000000
    - 1: 0000010000
    - 2: 0010000100
    - 3: 0010010010
    - 4: 0101001010
    - 5: 0101010101
    - 6: 1010110101
    - 7: 1101101101
    - 8: 1101111011
    - 9: 1111101111
  - Bit slot k of a frame (k=0 is the start bit) lasts BAUD_CYCLES + ADDITION[k mod 10] clocks.
- Handshake:
  - A byte transfers only on a clk edge where i_tvalid & o_tready.
  - FIFO_EA=0: o_tready = (state==S_IDLE). An accepted byte loads the shift register, and o_uart_tx goes low (start bit) on the next cycle. Latency from accept to falling edge is exactly 1 clk.
  - FIFO_EA>0: o_tready = FIFO not full. Write and read may occur on the same edge. When the FIFO is full, o_tready=0 and a byte offered with i_tvalid is held by the master, not dropped. When the FSM is in S_IDLE and the FIFO is non-empty, it pops one byte; the start bit begins within 2 clks of the pop decision.
  - Accepting a byte in the same cycle the previous frame ends is legal; frames are then sent back-to-back with no idle gap beyond the stop bits.
- FSM:
  - S_IDLE: line high; on load, go to S_START.
  - S_START: line low for slot 0.
  - S_DATA: bits 0..7 LSB first, slots 1..8.
  - S_PARITY: only when PARITY≠"NONE".
    - EVEN: parity bit = ^data.
    - ODD: parity bit = ~^data.
  - S_STOP: line high for STOP_BITS slots, then back to S_IDLE.
  - Per-slot cycle counter runs 1..slot_len and wraps to 1 on slot change; bit counter runs 0..7.
- Frame length:
  - 10 + (parity ? 1 : 0) + (STOP_BITS-1) slots.
  - For CLK_FREQ=1_000_000, BAUD_RATE=115200, NONE, 1 stop bit: 87 clks total.
- o_busy = (state≠S_IDLE) | FIFO non-empty. It falls on the cycle after the last stop-bit clock.
- o_uart_tx is a registered output with no combinational path from the inputs.
- i_tdata is ignored when i_tvalid=0; changing i_tdata mid-frame has no effect.

Decomposition:
- Shared package uart_pkg:
  - BAUD_CYCLES/FRAC calculation function.
  - ADDITION pattern lookup function.
  - Parity-mode constants.
  - Both uart_tx and the RX block use these.
- Sub-module uart_fifo_sync: parameterised by EA; write/read pointers with an extra wrap bit; full/empty flags. Instantiated only when FIFO_EA>0.

Test Plan:
1. CLK_FREQ=100, BAUD_RATE=10, NONE, FIFO_EA=0; send 0x55 -> o_uart_tx is 0,1,0,1,0,1,0,1,0 then stop 1, each level lasting 10 clks. Start bit goes low 1 clk after accept; o_tready is low for 100 clks.
2. Same clock and baud, EVEN then ODD parity; send 0x07 -> parity slot is 1 for EVEN and 0 for ODD; frame is 110 clks. With STOP_BITS=2, frame is 120 clks.
3. CLK_FREQ=1_000_000, BAUD_RATE=115200 (BAUD_CYCLES=8, FRAC=7); send 0xA3 -> slot lengths are 9,8,9,9,8,9,9,8,9,9 clks, for a total of 87 clks.
4. FIFO_EA=2; burst 6 bytes 0x01..0x06 with i_tvalid held high -> o_tready drops after 4 or 5 accepts; all 6 bytes are transmitted in order, back-to-back; o_busy stays high until the last stop bit ends.
5. Assert rstn=0 for 1 clk during bit 3 of 0xFF -> o_uart_tx=1 on the next edge; FIFO is empty; a subsequent 0x3C is transmitted cleanly.
6. Hold i_tvalid=0 for 1000 clks after reset -> o_uart_tx stays 1, o_busy stays 0, and o_tready is 1 (with FIFO) or 1 from the first post-reset cycle (without FIFO).
